// File: rtl/uart_pkg.sv
// Shared types and helpers for the parametrised UART receiver.
// State encoding, parity mode constants and counter sizing.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        BREAK_WAIT
    } state_e;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Counter width for a count range of n; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// RX pin synchroniser plus a 3-sample majority window.
// maj combines the current synchronised sample with the two before it.
module uart_rx_sampler #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic rx_in,
    output logic rxs,
    output logic maj
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [1:0]             hist_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q <= '1;
            hist_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_in};
            hist_q <= {hist_q[0], rxs};
        end
    end

    assign rxs = sync_q[SYNC_STAGES-1];
    assign maj = (rxs & hist_q[0]) | (rxs & hist_q[1]) | (hist_q[0] & hist_q[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: bit-timing FSM, shift register and a
// one-word output buffer with valid/ready handshake and overrun pulse.
module uart_rx_param #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 5208,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1,
    parameter int SYNC_STAGES  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rx_in,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  frame_err,
    output logic                  parity_err,
    output logic                  overrun_err,
    output logic                  busy
);
    import uart_pkg::*;

    localparam int CW = cnt_w(CLKS_PER_BIT);
    localparam int BW = cnt_w(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_DEC   = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  par_bad_q, par_bad_d;
    logic                  frm_bad_q, frm_bad_d;
    logic                  rxs, maj, dec, done, frm_fin, exp_par;

    uart_rx_sampler #(.SYNC_STAGES(SYNC_STAGES)) u_smp (
        .clk   (clk),
        .rst   (rst),
        .rx_in (rx_in),
        .rxs   (rxs),
        .maj   (maj)
    );

    assign dec     = (cnt_q == CNT_DEC);
    assign frm_fin = frm_bad_q | ~maj;
    assign exp_par = (PARITY == PAR_ODD) ? ~^shreg_q : ^shreg_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        par_bad_d = par_bad_q;
        frm_bad_d = frm_bad_q;
        done      = 1'b0;
        if (state_q != IDLE)
            cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CW'(1);
        case (state_q)
            IDLE: if (!rxs) begin
                cnt_d     = '0;
                bit_d     = '0;
                par_bad_d = 1'b0;
                frm_bad_d = 1'b0;
                state_d   = START;
            end
            START: if (dec) state_d = maj ? IDLE : DATA;
            DATA: if (dec) begin
                // LSB arrives first and ends up at bit 0 after DATA_WIDTH shifts.
                shreg_d = {maj, shreg_q[DATA_WIDTH-1:1]};
                if (bit_q == BIT_LAST) begin
                    bit_d   = '0;
                    state_d = (PARITY != PAR_NONE) ? uart_pkg::PARITY : STOP;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            uart_pkg::PARITY: if (dec) begin
                par_bad_d = (maj != exp_par);
                state_d   = STOP;
            end
            STOP: if (dec) begin
                frm_bad_d = frm_fin;
                if (bit_q == STOP_LAST) begin
                    // Leave STOP mid-bit so the next start edge is not missed.
                    done    = 1'b1;
                    state_d = frm_fin ? BREAK_WAIT : IDLE;
                end else begin
                    bit_d = bit_q + BW'(1);
                end
            end
            BREAK_WAIT: if (rxs) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            shreg_q   <= '0;
            par_bad_q <= 1'b0;
            frm_bad_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            shreg_q   <= shreg_d;
            par_bad_q <= par_bad_d;
            frm_bad_q <= frm_bad_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= shreg_q;
                    frame_err  <= frm_fin;
                    parity_err <= par_bad_q;
                    rx_valid   <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

    assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: three receivers (8N1, 7E1, 8N2) at 16 clocks per bit.
module tb_uart_rx_param;
    localparam int CPB = 16;

    typedef struct packed {
        logic [8:0] d;
        logic       fe;
        logic       pe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] rx  = '1;
    logic [2:0] rdy = '1;
    logic [2:0] vld, fe, pe, ovr, bsy;
    logic [7:0] d0, d2;
    logic [6:0] d1;
    int         checks = 0, failures = 0;
    int         ovc [3] = '{0, 0, 0};
    exp_t       q0 [$], q1 [$], q2 [$];

    always #5 clk = ~clk;

    uart_rx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u8n1 (
        .clk(clk), .rst(rst), .rx_in(rx[0]), .rx_data(d0), .rx_valid(vld[0]), .rx_ready(rdy[0]),
        .frame_err(fe[0]), .parity_err(pe[0]), .overrun_err(ovr[0]), .busy(bsy[0]));
    uart_rx_param #(.DATA_WIDTH(7), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u7e1 (
        .clk(clk), .rst(rst), .rx_in(rx[1]), .rx_data(d1), .rx_valid(vld[1]), .rx_ready(rdy[1]),
        .frame_err(fe[1]), .parity_err(pe[1]), .overrun_err(ovr[1]), .busy(bsy[1]));
    uart_rx_param #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u8n2 (
        .clk(clk), .rst(rst), .rx_in(rx[2]), .rx_data(d2), .rx_valid(vld[2]), .rx_ready(rdy[2]),
        .frame_err(fe[2]), .parity_err(pe[2]), .overrun_err(ovr[2]), .busy(bsy[2]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic push(input int k, input logic [8:0] d, input logic f, input logic p);
        exp_t e;
        e = '{d: d, fe: f, pe: p};
        case (k)
            0: q0.push_back(e);
            1: q1.push_back(e);
            default: q2.push_back(e);
        endcase
    endtask

    task automatic mon(input int k, input logic [8:0] d, input logic f, input logic p);
        exp_t e;
        bit   have;
        have = 1'b0;
        e    = '0;
        case (k)
            0: if (q0.size() > 0) begin e = q0.pop_front(); have = 1'b1; end
            1: if (q1.size() > 0) begin e = q1.pop_front(); have = 1'b1; end
            default: if (q2.size() > 0) begin e = q2.pop_front(); have = 1'b1; end
        endcase
        if (!have) begin
            checks++;
            failures++;
            $display("FAIL unexpected_word[%0d]: got %0h expected none", k, d);
        end else begin
            chk($sformatf("data[%0d]", k), 32'(d), 32'(e.d));
            chk($sformatf("frame_err[%0d]", k), 32'(f), 32'(e.fe));
            chk($sformatf("parity_err[%0d]", k), 32'(p), 32'(e.pe));
        end
    endtask

    // Words are checked at the handshake; ready changes just after posedge.
    always @(negedge clk) begin
        if (rst) begin
            if (vld[0] && rdy[0]) mon(0, {1'b0, d0}, fe[0], pe[0]);
            if (vld[1] && rdy[1]) mon(1, {2'b0, d1}, fe[1], pe[1]);
            if (vld[2] && rdy[2]) mon(2, {1'b0, d2}, fe[2], pe[2]);
            for (int k = 0; k < 3; k++) if (ovr[k]) ovc[k]++;
        end
    end

    task automatic setbit(input int k, input logic b);
        rx[k] = b;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic idle(input int k, input int nbits);
        for (int i = 0; i < nbits; i++) setbit(k, 1'b1);
    endtask

    // gbit >= 0 injects a one-cycle inverted glitch mid-way through that data bit.
    task automatic send(input int k, input logic [8:0] d, input int nb, input bit hasp,
                        input logic pb, input logic [1:0] stp, input int ns, input int gbit);
        setbit(k, 1'b0);
        for (int i = 0; i < nb; i++) begin
            if (i == gbit) begin
                rx[k] = d[i];
                repeat (8) @(negedge clk);
                rx[k] = ~d[i];
                @(negedge clk);
                rx[k] = d[i];
                repeat (CPB - 9) @(negedge clk);
            end else begin
                setbit(k, d[i]);
            end
        end
        if (hasp) setbit(k, pb);
        for (int i = 0; i < ns; i++) setbit(k, stp[i]);
    endtask

    initial begin
        int n;
        int ovb;
        repeat (3) @(negedge clk);
        chk("reset_flags", 32'({vld, fe, pe, ovr, bsy}), 32'h0);
        chk("reset_data", 32'({d0, d1, d2}), 32'h0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 8N1 basic word
        push(0, 9'hA5, 1'b0, 1'b0);
        send(0, 9'hA5, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        idle(0, 2);

        // 7E1: wrong then correct parity bit for 0x3C (even parity bit = 0)
        push(1, 9'h3C, 1'b0, 1'b1);
        send(1, 9'h3C, 7, 1'b1, 1'b1, 2'b11, 1, -1);
        idle(1, 1);
        push(1, 9'h3C, 1'b0, 1'b0);
        send(1, 9'h3C, 7, 1'b1, 1'b0, 2'b11, 1, -1);
        idle(1, 2);

        // false start: 4-cycle low pulse
        rx[0] = 1'b0;
        repeat (4) @(negedge clk);
        rx[0] = 1'b1;
        n = 0;
        while (bsy[0] && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("false_start_busy", 32'(bsy[0]), 32'h0);
        idle(0, 2);

        // glitch inside data bit 3 is voted out
        push(0, 9'hC3, 1'b0, 1'b0);
        send(0, 9'hC3, 8, 1'b0, 1'b0, 2'b11, 1, 3);
        idle(0, 2);

        // bad stop followed by a held break: one errored word only
        push(0, 9'h55, 1'b1, 1'b0);
        send(0, 9'h55, 8, 1'b0, 1'b0, 2'b00, 1, -1);
        repeat (5 * CPB) @(negedge clk);
        chk("break_busy", 32'(bsy[0]), 32'h1);
        idle(0, 2);
        push(0, 9'h12, 1'b0, 1'b0);
        send(0, 9'h12, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        idle(0, 2);

        // overrun: consumer stalled across two frames
        rdy[0] = 1'b0;
        ovb = ovc[0];
        push(0, 9'h11, 1'b0, 1'b0);
        send(0, 9'h11, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        send(0, 9'h22, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        idle(0, 2);
        chk("overrun_pulses", 32'(ovc[0] - ovb), 32'h1);
        chk("overrun_hold_valid", 32'(vld[0]), 32'h1);
        chk("overrun_hold_data", 32'(d0), 32'h11);
        @(posedge clk);
        #1 rdy[0] = 1'b1;
        @(negedge clk);
        chk("accept_valid_before", 32'(vld[0]), 32'h1);
        @(negedge clk);
        chk("accept_valid_drop", 32'(vld[0]), 32'h0);
        chk("accept_data_held", 32'(d0), 32'h11);

        // 8N2: second stop bit low
        push(2, 9'h3A, 1'b1, 1'b0);
        send(2, 9'h3A, 8, 1'b0, 1'b0, 2'b01, 2, -1);
        idle(2, 2);

        // reset in the middle of a data phase
        setbit(0, 1'b0);
        setbit(0, 1'b1);
        setbit(0, 1'b0);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midreset_flags", 32'({vld, fe, pe, ovr, bsy}), 32'h0);
        chk("midreset_data", 32'({d0, d1, d2}), 32'h0);
        rx[0] = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        idle(0, 1);
        push(0, 9'h7E, 1'b0, 1'b0);
        send(0, 9'h7E, 8, 1'b0, 1'b0, 2'b11, 1, -1);
        idle(0, 2);
        push(2, 9'h7E, 1'b0, 1'b0);
        send(2, 9'h7E, 8, 1'b0, 1'b0, 2'b11, 2, -1);
        idle(2, 2);

        chk("words_outstanding", 32'(q0.size() + q1.size() + q2.size()), 32'h0);
        chk("overrun_total", 32'(ovc[0] + ovc[1] + ovc[2]), 32'h1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no end of test expected finish");
        $fatal(1, "timeout");
    end

endmodule
